// File: rtl/tof_est_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tof_est_pkg
//  Purpose  : Shared definitions for the multi-channel time-of-flight
//             estimator: channel FSM state encoding, estimate saturation
//             helper and channel-index width helper.
//  Revision : 1.0  initial release
// ============================================================================
package tof_est_pkg;

    // Channel measurement FSM, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CNT_POS = 2'd1,
        ST_CNT_NEG = 2'd2,
        ST_DONE    = 2'd3
    } tof_state_t;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int tof_ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Clamp a signed value to the symmetric range [-(2^cw-1), 2^cw-1].
    function automatic logic signed [31:0] tof_sat(input logic signed [31:0] v,
                                                   input int                 cw);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< cw) - 32'sd1;
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tof_est_chan.sv
`default_nettype none
// ============================================================================
//  Module   : tof_est_chan
//  Purpose  : One X1/X2 channel. Synchronises both pulses, detects rising
//             edges, counts the signed delay between them and smooths the
//             result with a shift-gain first-order estimator.
//  Ports    : clk, reset    - clock, async active-high reset
//             x1, x2        - asynchronous pulse inputs
//             hold          - synchronised load request; parks FSM in IDLE
//             bypass        - store raw sample instead of filtering
//             w             - estimator gain shift
//             upd           - one-cycle pulse: est updated at this edge
//             est           - current signed estimate
//             timeout       - sticky: no closing edge within 2^CW-1 counts
//  Revision : 1.0  initial release
// ============================================================================
module tof_est_chan
    import tof_est_pkg::*;
#(
    parameter int CW = 8,
    parameter int WW = 3
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              x1,
    input  logic              x2,
    input  logic              hold,
    input  logic              bypass,
    input  logic [WW-1:0]     w,
    output logic              upd,
    output logic signed [CW:0] est,
    output logic              timeout
);

    localparam logic [CW-1:0] C_CNT_MAX = '1;

    // Two synchroniser flops plus one history flop per input.
    logic r_x1_m, r_x1_s, r_x1_p;
    logic r_x2_m, r_x2_s, r_x2_p;
    logic w_rise1, w_rise2;

    tof_state_t        r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt,   w_cnt_nxt;
    logic signed [CW:0] r_z,    w_z_nxt;
    logic signed [CW:0] r_est,  w_est_nxt;
    logic              r_init;
    logic              r_timeout;
    logic              w_upd;
    logic              w_tmo_set;

    // Estimator datapath is one bit wider than the difference needs so the
    // sum never wraps before saturation.
    logic signed [CW+2:0] w_diff, w_step, w_sum;
    logic signed [31:0]   w_sat;

    assign w_rise1 = r_x1_s & ~r_x1_p;
    assign w_rise2 = r_x2_s & ~r_x2_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_z_nxt     = r_z;
        w_upd       = 1'b0;
        w_tmo_set   = 1'b0;
        if (hold) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise1 & w_rise2) begin
                        w_state_nxt = ST_DONE;
                        w_z_nxt     = '0;
                    end else if (w_rise1) begin
                        w_state_nxt = ST_CNT_POS;
                        w_cnt_nxt   = CW'(1);
                    end else if (w_rise2) begin
                        w_state_nxt = ST_CNT_NEG;
                        w_cnt_nxt   = CW'(1);
                    end
                end
                // A closing edge on the terminal count still yields a sample.
                ST_CNT_POS: begin
                    if (w_rise2) begin
                        w_state_nxt = ST_DONE;
                        w_z_nxt     = $signed({1'b0, r_cnt});
                    end else if (r_cnt == C_CNT_MAX) begin
                        w_state_nxt = ST_IDLE;
                        w_tmo_set   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_CNT_NEG: begin
                    if (w_rise1) begin
                        w_state_nxt = ST_DONE;
                        w_z_nxt     = -$signed({1'b0, r_cnt});
                    end else if (r_cnt == C_CNT_MAX) begin
                        w_state_nxt = ST_IDLE;
                        w_tmo_set   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_upd       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_diff    = (CW+3)'(r_z) - (CW+3)'(r_est);
        w_step    = w_diff >>> w;
        w_sum     = (CW+3)'(r_est) + w_step;
        w_sat     = tof_sat(32'(w_sum), CW);
        w_est_nxt = (r_init | bypass) ? r_z : w_sat[CW:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x1_m    <= 1'b0;
            r_x1_s    <= 1'b0;
            r_x1_p    <= 1'b0;
            r_x2_m    <= 1'b0;
            r_x2_s    <= 1'b0;
            r_x2_p    <= 1'b0;
            r_cnt     <= '0;
            r_z       <= '0;
            r_est     <= '0;
            r_init    <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_x1_m <= x1;
            r_x1_s <= r_x1_m;
            r_x1_p <= r_x1_s;
            r_x2_m <= x2;
            r_x2_s <= r_x2_m;
            r_x2_p <= r_x2_s;
            r_cnt  <= w_cnt_nxt;
            r_z    <= w_z_nxt;
            if (w_upd) begin
                r_est  <= w_est_nxt;
                r_init <= 1'b0;
            end
            if (w_tmo_set) r_timeout <= 1'b1;
        end
    end

    assign upd     = w_upd;
    assign est     = r_est;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/tof_est_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tof_est_multi
//  Purpose  : NCH-channel signed time-of-flight estimator. Each channel
//             filters its own measurements; a round-robin arbiter serialises
//             fresh estimates onto one valid/ready port.
//  Ports    : clk, reset        - clock, async active-high reset
//             x1[NCH], x2[NCH]  - asynchronous pulse pairs
//             l_r, w_ext        - gain load request and gain value
//             est_data/est_ch/est_valid/est_ready - output handshake
//             timeout[NCH]      - sticky per-channel timeout flags
//             est_bypass        - only with TOF_EST_BYPASS_EN: store raw samples
//  Options  : TOF_EST_BYPASS_EN adds the est_bypass input.
//  Revision : 1.0  initial release
// ============================================================================
module tof_est_multi
    import tof_est_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CW    = 8,
    parameter int WW    = 3,
    parameter int W_RST = 2
)(
    input  logic                          clk,
    input  logic                          reset,
`ifdef TOF_EST_BYPASS_EN
    input  logic                          est_bypass,
`endif
    input  logic [NCH-1:0]                x1,
    input  logic [NCH-1:0]                x2,
    input  logic                          l_r,
    input  logic [WW-1:0]                 w_ext,
    output logic signed [CW:0]            est_data,
    output logic [tof_ch_width(NCH)-1:0]  est_ch,
    output logic                          est_valid,
    input  logic                          est_ready,
    output logic [NCH-1:0]                timeout
);

    localparam int CHW = tof_ch_width(NCH);

    logic                r_lr_m, r_lr_s, r_lr_p;
    logic [WW-1:0]       r_w;
    logic                w_bypass;

    logic [NCH-1:0]         w_upd;
    logic [NCH-1:0][CW:0]   w_est;
    logic [NCH-1:0]         r_pend;
    logic [CHW-1:0]         r_last;

    logic                w_gnt_vld;
    logic [CHW-1:0]      w_gnt_idx;
    logic [CHW-1:0]      w_idx_tmp;
    logic [NCH-1:0]      w_gnt_oh;
    logic                w_load;

    logic                r_valid;
    logic signed [CW:0]  r_data;
    logic [CHW-1:0]      r_ch;

    // Gain reloads only once the synchronised request has been seen on two
    // consecutive cycles, filtering single-cycle glitches on l_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lr_m <= 1'b0;
            r_lr_s <= 1'b0;
            r_lr_p <= 1'b0;
            r_w    <= WW'(W_RST);
        end else begin
            r_lr_m <= l_r;
            r_lr_s <= r_lr_m;
            r_lr_p <= r_lr_s;
            if (r_lr_s & r_lr_p) r_w <= w_ext;
        end
    end

`ifdef TOF_EST_BYPASS_EN
    logic r_byp_m, r_byp_s;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byp_m <= 1'b0;
            r_byp_s <= 1'b0;
        end else begin
            r_byp_m <= est_bypass;
            r_byp_s <= r_byp_m;
        end
    end
    assign w_bypass = r_byp_s;
`else
    assign w_bypass = 1'b0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        tof_est_chan #(
            .CW (CW),
            .WW (WW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .x1      (x1[g]),
            .x2      (x2[g]),
            .hold    (r_lr_s),
            .bypass  (w_bypass),
            .w       (r_w),
            .upd     (w_upd[g]),
            .est     (w_est[g]),
            .timeout (timeout[g])
        );
    end

    // Round-robin search starting just after the last granted channel.
    // Scanning from the far end downward lets the nearest candidate win.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx_tmp = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_idx_tmp = CHW'((int'(r_last) + k) % NCH);
            if (r_pend[w_idx_tmp]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx_tmp;
            end
        end
    end

    // Load while the register is empty or being drained this cycle; no new
    // words start while a gain load is in progress.
    assign w_load   = ~r_lr_s & (~r_valid | est_ready) & w_gnt_vld;
    assign w_gnt_oh = w_load ? (NCH'(1) << w_gnt_idx) : '0;

    // The last grant resets to the top channel so the first search
    // starts at channel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= CHW'(NCH-1);
            r_pend  <= '0;
        end else begin
            // An update landing on the channel being granted re-arms pend.
            r_pend <= (r_pend & ~w_gnt_oh) | w_upd;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_est[w_gnt_idx];
                r_ch    <= w_gnt_idx;
                r_last  <= w_gnt_idx;
            end else if (est_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign est_valid = r_valid;
    assign est_data  = r_data;
    assign est_ch    = r_ch;

endmodule
`default_nettype wire
